fpnew_issue_rob: RTL and testbench
==================================

// Module: fpnew_issue_rob
// PURPOSE
//  Core-side initiator for the FPU request/response handshake. Issues ops from the core to the FPU top level.
//  Tags each op with a reorder-buffer (ROB) slot index. Accepts FPU results out of order (the FPU arbitrates
//  its op groups round-robin) and writes them back to the core in strict issue order.
// PARAMETERS
//  Width  32  operand/result width; must equal the FPU Width
//  Depth  4   max outstanding ops; power of two, >=2
//  TagW   $clog2(Depth) (localparam)  tag width driven to/expected from the FPU
// PORTS
//  clk_i        in   1         clock, rising edge
//  rst_i        in   1         synchronous reset, active-high
//  req_valid_i  in   1         core op valid
//  req_ready_o  out  1         core op accepted
//  req_i        in   req_t     operands[3][Width], rnd, op, op_mod, src/dst/int fmt, vectorial, rd[4:0]
//  flush_i      in   1         squash everything in flight
//  fpu_valid_o  out  1         FPU in_valid
//  fpu_ready_i  in   1         FPU in_ready
//  fpu_req_o    out  fpu_req_t req_i fields minus rd
//  fpu_tag_o    out  TagW      FPU tag_i = ROB slot
//  fpu_flush_o  out  1         FPU flush_i
//  fpu_valid_i  in   1         FPU out_valid
//  fpu_ready_o  out  1         FPU out_ready
//  fpu_result_i in   Width     FPU result
//  fpu_status_i in   5         FPU status flags (NV,DZ,OF,UF,NX)
//  fpu_tag_i    in   TagW      FPU tag_o
//  wb_valid_o   out  1         in-order writeback valid
//  wb_ready_i   in   1         writeback accepted
//  wb_rd_o      out  5         destination register
//  wb_result_o  out  Width     result
//  wb_status_o  out  5         flags of the retiring op
//  fflags_o     out  5         sticky accumulated flags (feature only)
//  fflags_clr_i in   1         clear fflags_o (feature only)
//  busy_o       out  1         any slot occupied
// BEHAVIOUR
//  - State: head/tail ptrs, TagW+1 bits each (wrap bit). count = tail-head. Per-slot pend, done, rd, result, status.
//  - full = (count==Depth); empty = (count==0). busy_o = !empty.
//  - Issue (comb. pass-through): fpu_valid_o = req_valid_i & !full & !flush_i.
//    req_ready_o = fpu_valid_o & fpu_ready_i. fpu_tag_o = tail[TagW-1:0].
//  - On issue handshake: slot[tail].pend=1, done=0, rd latched; tail++. Zero added latency.
//  - Response: fpu_ready_o = 1 always; every in-flight op already owns a slot.
//    On fpu_valid_i, if slot[fpu_tag_i].pend & !done: store result and status, done=1.
//    Otherwise the beat is dropped; only a stale post-flush beat can hit this.
//  - Retire: wb_valid_o = slot[head].pend & slot[head].done; wb_* = slot[head] fields, all registered.
//    On wb handshake: pend=0, head++.
//  - Minimum FPU-result-to-wb_valid_o latency is 1 cycle. No wb bypass.
//  - Simultaneous events in one cycle are all legal: issue, response and retire; response to head plus retire
//    of the old head; issue into the slot freed by the same cycle's retire when full.
//    full is evaluated before that cycle's retire, so that issue stalls 1 cycle.
//  - flush_i: fpu_flush_o = flush_i (comb.). Next cycle: head=tail=0, all pend/done=0. No issue in the flush cycle.
//    Responses and retires in the flush cycle are discarded (wb_valid_o forced 0 that cycle).
//  - Reset: all pointers and flags 0. Outputs: req_ready_o=0, fpu_valid_o=0, wb_valid_o=0,
//    wb_rd_o/result/status=0, fflags_o=0, busy_o=0. fpu_ready_o=1 after reset.
//    Reset mid-operation behaves as flush; the FPU must be reset concurrently.
// CONFIGURATION
//  - FPNEW_ISSUE_ROB_FFLAGS_EN defined: fflags_o |= wb_status_o on each wb handshake.
//    fflags_clr_i clears it; if clear and handshake coincide, the result is the new status only.
//  - Macro undefined: fflags_o tied 0, fflags_clr_i ignored, no register.
// STRUCTURE
//  - Package fpnew_issue_pkg: req_t, fpu_req_t (reuses fpnew_pkg enums), rob_entry_t {pend,done,rd,result,status},
//    STATUS_W=5.
//  - Single module, no sub-module. Slot storage is a flop array sized Depth.
// TESTING
//  - Reset then idle: all outputs at reset values, fpu_ready_o=1, busy_o=0.
//  - Issue 4 ops (Depth=4), rd=1..4: tags 0,1,2,3; 5th stalls (req_ready_o=0). FPU returns tags 2,0,3,1.
//    Required: wb rd order 1,2,3,4; retire of tag 0 frees issue next cycle.
//  - Full ROB, head done, wb_ready_i=1 and req_valid_i=1: retire this cycle, issue the following cycle with tag 0
//    (after wrap).
//  - Response tag 0 with result 0x3F800000, status 5'b00001, same cycle wb_ready_i=1:
//    wb_valid_o rises next cycle with exactly those values.
//  - Flush with 3 in flight plus a response beat that cycle: fpu_flush_o=1, no wb.
//    busy_o=0 next cycle; a late beat with tag 1 is dropped.
//  - FFLAGS_EN: retire statuses 5'b00001 then 5'b10000 -> fflags_o=5'b10001.
//    fflags_clr_i coincident with a 5'b00100 retire -> 5'b00100.

Source files
------------

// File: rtl/fpnew_issue_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fpnew_issue_pkg
//  Description : Shared types for the core-side FPU issue/reorder block.
//                Holds the core request, the FPU-facing request (request
//                without the destination register), the per-slot ROB
//                entry, and the FPU enumerations used by both.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpnew_issue_pkg;

    // Datapath width of operands/results; the FPU is built with the same width.
    localparam int unsigned FP_WIDTH     = 32;
    localparam int unsigned STATUS_W     = 5;
    localparam int unsigned NUM_OPERANDS = 3;
    localparam int unsigned RD_W         = 5;

    // Rounding modes, encoded as in the FPU.
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    // Operation codes, encoded as in the FPU.
    typedef enum logic [3:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CMP      = 4'd8,
        CLASSIFY = 4'd9,
        F2F      = 4'd10,
        F2I      = 4'd11,
        I2F      = 4'd12,
        CPKAB    = 4'd13,
        CPKCD    = 4'd14
    } operation_e;

    // Floating-point formats.
    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    // Integer formats.
    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1,
        INT32 = 2'd2,
        INT64 = 2'd3
    } int_format_e;

    // Request as presented by the core.
    typedef struct packed {
        logic [NUM_OPERANDS-1:0][FP_WIDTH-1:0] operands;
        roundmode_e                            rnd_mode;
        operation_e                            op;
        logic                                  op_mod;
        fp_format_e                            src_fmt;
        fp_format_e                            dst_fmt;
        int_format_e                           int_fmt;
        logic                                  vectorial_op;
        logic [RD_W-1:0]                       rd;
    } req_t;

    // Request as presented to the FPU: the destination register stays in the ROB.
    typedef struct packed {
        logic [NUM_OPERANDS-1:0][FP_WIDTH-1:0] operands;
        roundmode_e                            rnd_mode;
        operation_e                            op;
        logic                                  op_mod;
        fp_format_e                            src_fmt;
        fp_format_e                            dst_fmt;
        int_format_e                           int_fmt;
        logic                                  vectorial_op;
    } fpu_req_t;

    // One reorder-buffer slot.
    typedef struct packed {
        logic                pend;
        logic                done;
        logic [RD_W-1:0]     rd;
        logic [FP_WIDTH-1:0] result;
        logic [STATUS_W-1:0] status;
    } rob_entry_t;

    // Strip the destination register from a core request.
    function automatic fpu_req_t to_fpu_req(input req_t req);
        fpu_req_t r;
        r.operands     = req.operands;
        r.rnd_mode     = req.rnd_mode;
        r.op           = req.op;
        r.op_mod       = req.op_mod;
        r.src_fmt      = req.src_fmt;
        r.dst_fmt      = req.dst_fmt;
        r.int_fmt      = req.int_fmt;
        r.vectorial_op = req.vectorial_op;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_issue_rob.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fpnew_issue_rob
//  Description : Core-side FPU initiator. Issues core ops to the FPU tagged
//                with a reorder-buffer slot index, accepts results in any
//                order and writes them back to the core in issue order.
//                Optional sticky exception flags: define
//                FPNEW_ISSUE_ROB_FFLAGS_EN to build the fflags register.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpnew_issue_rob
    import fpnew_issue_pkg::*;
#(
    parameter int unsigned WIDTH = FP_WIDTH,   // must match the FPU width
    parameter int unsigned DEPTH = 4,          // power of two, >= 2
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // Core request side
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  req_t                req_i,
    input  logic                flush_i,
    // FPU request side
    output logic                fpu_valid_o,
    input  logic                fpu_ready_i,
    output fpu_req_t            fpu_req_o,
    output logic [TAG_W-1:0]    fpu_tag_o,
    output logic                fpu_flush_o,
    // FPU response side
    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    input  logic [WIDTH-1:0]    fpu_result_i,
    input  logic [STATUS_W-1:0] fpu_status_i,
    input  logic [TAG_W-1:0]    fpu_tag_i,
    // In-order writeback
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [RD_W-1:0]     wb_rd_o,
    output logic [WIDTH-1:0]    wb_result_o,
    output logic [STATUS_W-1:0] wb_status_o,
    // Sticky flags and status
    output logic [STATUS_W-1:0] fflags_o,
    input  logic                fflags_clr_i,
    output logic                busy_o
);

    localparam logic [TAG_W:0] C_DEPTH_CNT = DEPTH[TAG_W:0];
    localparam logic [TAG_W:0] C_PTR_INC   = {{TAG_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]   r_head;
    logic [TAG_W:0]   r_tail;
    rob_entry_t       r_slots [DEPTH];

    logic [TAG_W:0]   w_count;
    logic             w_full;
    logic             w_empty;
    logic [TAG_W-1:0] w_head_idx;
    logic [TAG_W-1:0] w_tail_idx;
    rob_entry_t       w_head_entry;
    rob_entry_t       w_resp_entry;
    logic             w_fpu_valid;
    logic             w_issue;
    logic             w_resp;
    logic             w_wb_valid;
    logic             w_retire;

    assign w_count    = r_tail - r_head;
    // Full is judged before this cycle's retire, so a retire from a full ROB
    // only lets the next issue through one cycle later.
    assign w_full     = (w_count == C_DEPTH_CNT);
    assign w_empty    = (w_count == '0);
    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];

    assign w_head_entry = r_slots[w_head_idx];
    assign w_resp_entry = r_slots[fpu_tag_i];

    // Issue is a combinational pass-through; nothing is issued while flushing or in reset.
    assign w_fpu_valid = req_valid_i & ~w_full & ~flush_i & ~rst_i;
    assign w_issue     = w_fpu_valid & fpu_ready_i;

    assign fpu_valid_o = w_fpu_valid;
    assign req_ready_o = w_issue;
    assign fpu_req_o   = to_fpu_req(req_i);
    assign fpu_tag_o   = w_tail_idx;
    assign fpu_flush_o = flush_i;

    // Every in-flight op already owns a slot, so results are always accepted.
    assign fpu_ready_o = 1'b1;

    // Only beats for a live, not-yet-completed slot are stored; stale beats
    // arriving after a flush fall through here and are dropped.
    assign w_resp = fpu_valid_i & w_resp_entry.pend & ~w_resp_entry.done & ~flush_i;

    // Writeback comes only from registered slot state (no bypass of the FPU result).
    assign w_wb_valid = w_head_entry.pend & w_head_entry.done & ~flush_i & ~rst_i;
    assign w_retire   = w_wb_valid & wb_ready_i;

    assign wb_valid_o  = w_wb_valid;
    assign wb_rd_o     = w_head_entry.rd;
    assign wb_result_o = w_head_entry.result;
    assign wb_status_o = w_head_entry.status;

    assign busy_o = ~w_empty;

    // Head/tail pointers: advance on retire/issue, collapse to zero on flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_retire) begin
                r_head <= r_head + C_PTR_INC;
            end
            if (w_issue) begin
                r_tail <= r_tail + C_PTR_INC;
            end
        end
    end

    // Slot storage. Response, retire and issue never target the same slot in
    // one cycle: a retiring slot is already done, and the issue slot is free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].pend <= 1'b0;
                r_slots[i].done <= 1'b0;
            end
        end else begin
            if (w_resp) begin
                r_slots[fpu_tag_i].result <= fpu_result_i;
                r_slots[fpu_tag_i].status <= fpu_status_i;
                r_slots[fpu_tag_i].done   <= 1'b1;
            end
            if (w_retire) begin
                r_slots[w_head_idx].pend <= 1'b0;
                r_slots[w_head_idx].done <= 1'b0;
            end
            if (w_issue) begin
                r_slots[w_tail_idx].pend <= 1'b1;
                r_slots[w_tail_idx].done <= 1'b0;
                r_slots[w_tail_idx].rd   <= req_i.rd;
            end
        end
    end

`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
    logic [STATUS_W-1:0] r_fflags;

    // Sticky flags: OR in each retiring status; a clear coinciding with a
    // retire leaves just the new status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fflags <= '0;
        end else if (w_retire) begin
            r_fflags <= fflags_clr_i ? w_head_entry.status : (r_fflags | w_head_entry.status);
        end else if (fflags_clr_i) begin
            r_fflags <= '0;
        end
    end

    assign fflags_o = r_fflags;
`else
    logic w_unused_fflags_clr;

    assign fflags_o            = '0;
    assign w_unused_fflags_clr = fflags_clr_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpnew_issue_rob.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fpnew_issue_rob
//  Description : Self-checking bench for fpnew_issue_rob (DEPTH=4). Directed
//                scenarios plus a randomized run against a queue-based model
//                of in-order retirement with an out-of-order FPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpnew_issue_rob;
    import fpnew_issue_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 2;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                req_valid_i;
    logic                req_ready_o;
    req_t                req_i;
    logic                flush_i;
    logic                fpu_valid_o;
    logic                fpu_ready_i;
    fpu_req_t            fpu_req_o;
    logic [TAG_W-1:0]    fpu_tag_o;
    logic                fpu_flush_o;
    logic                fpu_valid_i;
    logic                fpu_ready_o;
    logic [WIDTH-1:0]    fpu_result_i;
    logic [STATUS_W-1:0] fpu_status_i;
    logic [TAG_W-1:0]    fpu_tag_i;
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [RD_W-1:0]     wb_rd_o;
    logic [WIDTH-1:0]    wb_result_o;
    logic [STATUS_W-1:0] wb_status_o;
    logic [STATUS_W-1:0] fflags_o;
    logic                fflags_clr_i;
    logic                busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    fpnew_issue_rob #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i), .flush_i(flush_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_req_o(fpu_req_o),
        .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o), .fpu_result_i(fpu_result_i),
        .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_result_o(wb_result_o), .wb_status_o(wb_status_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i  = 1'b0;
        req_i        = '0;
        flush_i      = 1'b0;
        fpu_ready_i  = 1'b1;
        fpu_valid_i  = 1'b0;
        fpu_result_i = '0;
        fpu_status_i = '0;
        fpu_tag_i    = '0;
        wb_ready_i   = 1'b0;
        fflags_clr_i = 1'b0;
    endtask

    task automatic drive_issue(input logic [RD_W-1:0] rd);
        req_valid_i          = 1'b1;
        req_i.operands[0]    = $urandom;
        req_i.operands[1]    = $urandom;
        req_i.operands[2]    = $urandom;
        req_i.rnd_mode       = RTZ;
        req_i.op             = ($urandom_range(0, 1) != 0) ? MUL : ADD;
        req_i.op_mod         = 1'($urandom_range(0, 1));
        req_i.src_fmt        = FP32;
        req_i.dst_fmt        = FP32;
        req_i.int_fmt        = INT32;
        req_i.vectorial_op   = 1'b0;
        req_i.rd             = rd;
    endtask

    task automatic drive_resp(input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] res,
                              input logic [STATUS_W-1:0] st);
        fpu_valid_i  = 1'b1;
        fpu_tag_i    = tag;
        fpu_result_i = res;
        fpu_status_i = st;
    endtask

    // Flush plus a sticky-flag clear: leaves the ROB empty with tags restarting at 0.
    task automatic do_flush();
        idle_inputs();
        flush_i      = 1'b1;
        fflags_clr_i = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready_o); end
        n_tests++; if (fpu_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_valid: got %b want 0", fpu_valid_o); end
        n_tests++; if (fpu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_fpu_ready: got %b want 1", fpu_ready_o); end
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
        n_tests++; if (wb_rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_wb_rd: got %h want 0", wb_rd_o); end
        n_tests++; if (wb_result_o !== 32'd0) begin n_fail++; $display("FAIL reset_wb_result: got %h want 0", wb_result_o); end
        n_tests++; if (wb_status_o !== 5'd0) begin n_fail++; $display("FAIL reset_wb_status: got %h want 0", wb_status_o); end
        n_tests++; if (fflags_o !== 5'd0) begin n_fail++; $display("FAIL reset_fflags: got %h want 0", fflags_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_tests++; if (fpu_flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_flush: got %b want 0", fpu_flush_o); end
        tick();
    endtask

    // Four ops fill the ROB, a fifth stalls, FPU answers 2,0,3,1, writeback stays in order.
    task automatic test_fill_ooo();
        logic [WIDTH-1:0]    res [DEPTH];
        logic [STATUS_W-1:0] st  [DEPTH];
        int                  resp_order [DEPTH] = '{2, 0, 3, 1};
        int                  n_wb = 0;
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive_issue(5'(i + 1));
            #1;
            n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 1", i, req_ready_o); end
            n_tests++; if (fpu_tag_o !== 2'(i)) begin n_fail++; $display("FAIL fill_tag[%0d]: got %0d want %0d", i, fpu_tag_o, i); end
            tick();
        end
        drive_issue(5'd5);
        #1;
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_stall_ready: got %b want 0", req_ready_o); end
        n_tests++; if (fpu_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_stall_fpu_valid: got %b want 0", fpu_valid_o); end
        tick();
        req_valid_i = 1'b0;
        wb_ready_i  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            res[i] = $urandom;
            st[i]  = 5'($urandom_range(0, 31));
        end
        for (int cyc = 0; cyc < 20 && n_wb < DEPTH; cyc++) begin
            fpu_valid_i = 1'b0;
            if (cyc < DEPTH) drive_resp(2'(resp_order[cyc]), res[resp_order[cyc]], st[resp_order[cyc]]);
            #1;
            if (wb_valid_o === 1'b1) begin
                n_tests++; if (wb_rd_o !== 5'(n_wb + 1)) begin n_fail++; $display("FAIL ooo_wb_rd[%0d]: got %0d want %0d", n_wb, wb_rd_o, n_wb + 1); end
                n_tests++; if (wb_result_o !== res[n_wb]) begin n_fail++; $display("FAIL ooo_wb_result[%0d]: got %h want %h", n_wb, wb_result_o, res[n_wb]); end
                n_tests++; if (wb_status_o !== st[n_wb]) begin n_fail++; $display("FAIL ooo_wb_status[%0d]: got %h want %h", n_wb, wb_status_o, st[n_wb]); end
                n_wb++;
            end
            tick();
        end
        idle_inputs();
        #1;
        n_tests++; if (n_wb !== DEPTH) begin n_fail++; $display("FAIL ooo_wb_count: got %0d want %0d", n_wb, DEPTH); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ooo_busy_after: got %b want 0", busy_o); end
        tick();
    endtask

    // Full ROB, head done, retire and issue requested together: issue follows one cycle later with tag 0.
    task automatic test_back_to_back();
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            drive_issue(5'(10 + i));
            tick();
        end
        req_valid_i = 1'b0;
        drive_resp(2'd0, 32'hCAFE_0000, 5'd0);
        tick();
        fpu_valid_i = 1'b0;
        drive_issue(5'd14);
        wb_ready_i = 1'b1;
        #1;
        n_tests++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_wb_valid: got %b want 1", wb_valid_o); end
        n_tests++; if (wb_rd_o !== 5'd10) begin n_fail++; $display("FAIL b2b_wb_rd: got %0d want 10", wb_rd_o); end
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_same_cycle_ready: got %b want 0", req_ready_o); end
        tick();
        n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_next_ready: got %b want 1", req_ready_o); end
        n_tests++; if (fpu_tag_o !== 2'd0) begin n_fail++; $display("FAIL b2b_wrap_tag: got %0d want 0", fpu_tag_o); end
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_wb_after: got %b want 0", wb_valid_o); end
        tick();
        idle_inputs();
        tick();
    endtask

    // Response and writeback-ready in one cycle: writeback appears the next cycle, no bypass.
    task automatic test_resp_latency();
        do_flush();
        drive_issue(5'd7);
        tick();
        req_valid_i = 1'b0;
        drive_resp(2'd0, 32'h3F80_0000, 5'b00001);
        wb_ready_i = 1'b1;
        #1;
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_no_bypass: got %b want 0", wb_valid_o); end
        tick();
        fpu_valid_i = 1'b0;
        #1;
        n_tests++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_wb_valid: got %b want 1", wb_valid_o); end
        n_tests++; if (wb_result_o !== 32'h3F80_0000) begin n_fail++; $display("FAIL lat_wb_result: got %h want 3f800000", wb_result_o); end
        n_tests++; if (wb_status_o !== 5'b00001) begin n_fail++; $display("FAIL lat_wb_status: got %b want 00001", wb_status_o); end
        n_tests++; if (wb_rd_o !== 5'd7) begin n_fail++; $display("FAIL lat_wb_rd: got %0d want 7", wb_rd_o); end
        tick();
        wb_ready_i = 1'b0;
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL lat_busy_after: got %b want 0", busy_o); end
        tick();
    endtask

    // Flush with three in flight, head done, and a beat in the flush cycle; later a stale beat.
    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 3; i++) begin
            drive_issue(5'(20 + i));
            tick();
        end
        req_valid_i = 1'b0;
        drive_resp(2'd0, 32'h1111_1111, 5'd1);
        tick();
        drive_resp(2'd2, 32'h2222_2222, 5'd2);
        flush_i     = 1'b1;
        wb_ready_i  = 1'b1;
        drive_issue(5'd23);
        #1;
        n_tests++; if (fpu_flush_o !== 1'b1) begin n_fail++; $display("FAIL flush_fpu_flush: got %b want 1", fpu_flush_o); end
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_wb_valid: got %b want 0", wb_valid_o); end
        n_tests++; if (fpu_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_fpu_valid: got %b want 0", fpu_valid_o); end
        n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_req_ready: got %b want 0", req_ready_o); end
        tick();
        idle_inputs();
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy_next: got %b want 0", busy_o); end
        n_tests++; if (fpu_flush_o !== 1'b0) begin n_fail++; $display("FAIL flush_release: got %b want 0", fpu_flush_o); end
        drive_resp(2'd1, 32'hDEAD_BEEF, 5'd4);
        tick();
        fpu_valid_i = 1'b0;
        #1;
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL stale_wb_valid: got %b want 0", wb_valid_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL stale_busy: got %b want 0", busy_o); end
        drive_issue(5'd30);
        #1;
        n_tests++; if (fpu_tag_o !== 2'd0) begin n_fail++; $display("FAIL flush_restart_tag: got %0d want 0", fpu_tag_o); end
        tick();
        req_valid_i = 1'b0;
        #1;
        n_tests++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_old_beat_dropped: got %b want 0", wb_valid_o); end
        drive_resp(2'd0, 32'h5555_AAAA, 5'd8);
        tick();
        fpu_valid_i = 1'b0;
        wb_ready_i  = 1'b1;
        #1;
        n_tests++; if (wb_result_o !== 32'h5555_AAAA || wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_new_result: got %h/%b want 5555aaaa/1", wb_result_o, wb_valid_o); end
        tick();
        idle_inputs();
        tick();
    endtask

    // Sticky flags: 00001 then 10000 accumulate; a clear with a 00100 retire leaves 00100.
    task automatic test_fflags();
        logic [STATUS_W-1:0] exp_a;
        logic [STATUS_W-1:0] exp_b;
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
        exp_a = 5'b10001;
        exp_b = 5'b00100;
`else
        exp_a = 5'b00000;
        exp_b = 5'b00000;
`endif
        do_flush();
        for (int i = 0; i < 3; i++) begin
            drive_issue(5'(i + 1));
            tick();
        end
        req_valid_i = 1'b0;
        drive_resp(2'd0, 32'd1, 5'b00001); tick();
        drive_resp(2'd1, 32'd2, 5'b10000); tick();
        drive_resp(2'd2, 32'd3, 5'b00100); tick();
        fpu_valid_i = 1'b0;
        wb_ready_i  = 1'b1;
        tick();
        tick();
        wb_ready_i = 1'b0;
        #1;
        n_tests++; if (fflags_o !== exp_a) begin n_fail++; $display("FAIL fflags_accum: got %b want %b", fflags_o, exp_a); end
        wb_ready_i   = 1'b1;
        fflags_clr_i = 1'b1;
        #1;
        n_tests++; if (wb_status_o !== 5'b00100 || wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL fflags_third_wb: got %b/%b want 00100/1", wb_status_o, wb_valid_o); end
        tick();
        idle_inputs();
        #1;
        n_tests++; if (fflags_o !== exp_b) begin n_fail++; $display("FAIL fflags_clr_retire: got %b want %b", fflags_o, exp_b); end
        tick();
    endtask

    // Random traffic against a model: ops retire in issue order once their result has arrived.
    task automatic test_random();
        int                  ord_q[$];       // tags in issue order, not yet retired
        int                  inflight[$];    // tags accepted by the FPU, no result yet
        logic [RD_W-1:0]     m_rd   [DEPTH];
        logic [WIDTH-1:0]    m_res  [DEPTH];
        logic [STATUS_W-1:0] m_st   [DEPTH];
        bit                  m_done [DEPTH];
        logic [STATUS_W-1:0] m_ff = '0;
        int                  issued = 0;
        int                  ridx;
        int                  rtag;
        bit                  exp_ready;
        bit                  exp_wb;
        bit                  retire;
        do_flush();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle_inputs();
            if ($urandom_range(0, 3) != 0) drive_issue(5'($urandom_range(0, 31)));
            fpu_ready_i  = ($urandom_range(0, 3) != 0);
            wb_ready_i   = ($urandom_range(0, 2) != 0);
            fflags_clr_i = ($urandom_range(0, 15) == 0);
            ridx = -1;
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                ridx = $urandom_range(0, inflight.size() - 1);
                rtag = inflight[ridx];
                drive_resp(2'(rtag), $urandom, 5'($urandom_range(0, 31)));
            end
            #1;
            exp_ready = req_valid_i && (ord_q.size() < DEPTH) && fpu_ready_i;
            exp_wb    = (ord_q.size() > 0) && m_done[ord_q[0]];
            n_tests++; if (req_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_req_ready c%0d: got %b want %b", cyc, req_ready_o, exp_ready); end
            if (req_valid_i && ord_q.size() < DEPTH) begin
                n_tests++; if (fpu_tag_o !== 2'(issued % DEPTH)) begin n_fail++; $display("FAIL rnd_tag c%0d: got %0d want %0d", cyc, fpu_tag_o, issued % DEPTH); end
                n_tests++; if (fpu_req_o.operands !== req_i.operands || fpu_req_o.op !== req_i.op) begin n_fail++; $display("FAIL rnd_fpu_req c%0d: got %h want %h", cyc, fpu_req_o.operands, req_i.operands); end
            end
            n_tests++; if (wb_valid_o !== exp_wb) begin n_fail++; $display("FAIL rnd_wb_valid c%0d: got %b want %b", cyc, wb_valid_o, exp_wb); end
            if (exp_wb) begin
                n_tests++;
                if (wb_rd_o !== m_rd[ord_q[0]] || wb_result_o !== m_res[ord_q[0]] || wb_status_o !== m_st[ord_q[0]]) begin
                    n_fail++;
                    $display("FAIL rnd_wb_data c%0d: got rd=%0d res=%h st=%h want rd=%0d res=%h st=%h", cyc,
                             wb_rd_o, wb_result_o, wb_status_o, m_rd[ord_q[0]], m_res[ord_q[0]], m_st[ord_q[0]]);
                end
            end
            n_tests++; if (busy_o !== (ord_q.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy_o, ord_q.size() != 0); end
            n_tests++; if (fflags_o !== m_ff) begin n_fail++; $display("FAIL rnd_fflags c%0d: got %b want %b", cyc, fflags_o, m_ff); end
            // Model update for the coming clock edge.
            retire = exp_wb && wb_ready_i;
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
            if (retire) m_ff = fflags_clr_i ? m_st[ord_q[0]] : (m_ff | m_st[ord_q[0]]);
            else if (fflags_clr_i) m_ff = '0;
`endif
            if (retire) void'(ord_q.pop_front());
            if (ridx >= 0) begin
                m_done[rtag] = 1'b1;
                m_res[rtag]  = fpu_result_i;
                m_st[rtag]   = fpu_status_i;
                inflight.delete(ridx);
            end
            if (exp_ready) begin
                ord_q.push_back(issued % DEPTH);
                inflight.push_back(issued % DEPTH);
                m_rd[issued % DEPTH]   = req_i.rd;
                m_done[issued % DEPTH] = 1'b0;
                issued++;
            end
            tick();
        end
        do_flush();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_fill_ooo();
        test_back_to_back();
        test_resp_latency();
        test_flush();
        test_fflags();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
